// File: rtl/cla_sub_64_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_sub_64_pipe_pkg
// Description : Shared sizing defaults and the 16-bit carry-lookahead helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cla_sub_64_pipe_pkg;

  localparam int DEF_WIDTH   = 64;
  localparam int DEF_SLICE_W = 16;
  localparam int DEF_NS      = DEF_WIDTH / DEF_SLICE_W;

  typedef struct packed {
    logic [15:0] sum;
    logic        g;
    logic        p;
  } cla16_t;

  // Carry out of the slice is g | (p & cin); callers form it from g/p.
  function automatic cla16_t cla16(input logic [15:0] x, input logic [15:0] y,
                                   input logic cin);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  gc;
    cla16_t      r;
    g = x & y;
    p = x ^ y;
    for (int i = 0; i < 4; i++) begin
      gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gp[i] = &p[4*i +: 4];
    end
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
    for (int i = 0; i < 4; i++) begin
      c[4*i] = gc[i];
      for (int j = 1; j < 4; j++) begin
        c[4*i+j] = g[4*i+j-1] | (p[4*i+j-1] & c[4*i+j-1]);
      end
    end
    r.sum = p ^ c;
    r.g   = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
    r.p   = &gp;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_sub_64_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : cla_sub_16_stage
// Description : One registered subtract slice with valid/ready and operand skew.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_sub_16_stage
  import cla_sub_64_pipe_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SLICE_W = DEF_SLICE_W,
  parameter int IDX     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             ready_i,
  output logic             valid_o,
  input  logic             carry_i,
  input  logic             z_i,
  input  logic             amsb_i,
  input  logic [WIDTH-1:0] res_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             carry_o,
  output logic             z_o,
  output logic             amsb_o,
  output logic [WIDTH-1:0] res_o,
  output logic [WIDTH-1:0] b_o
);

  localparam int LO = IDX * SLICE_W;

  cla16_t           w_s;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             z_d;
  logic             valid_q;
  logic             carry_q;
  logic             z_q;
  logic             amsb_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] b_q;

  // res_i carries finished result slices below LO and raw minuend slices above.
  always_comb begin
    w_s                 = cla16(res_i[LO +: SLICE_W], ~b_i[LO +: SLICE_W], carry_i);
    res_d               = res_i;
    res_d[LO +: SLICE_W] = w_s.sum;
    carry_d             = w_s.g | (w_s.p & carry_i);
    z_d                 = z_i & (w_s.sum == '0);
  end

  assign ready_o = ~valid_q | ready_i;

  // Carry resets to 1 so the derived borrow-out reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b1;
      z_q     <= 1'b0;
      amsb_q  <= 1'b0;
      res_q   <= '0;
      b_q     <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        carry_q <= carry_d;
        z_q     <= z_d;
        amsb_q  <= amsb_i;
        res_q   <= res_d;
        b_q     <= b_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign carry_o = carry_q;
  assign z_o     = z_q;
  assign amsb_o  = amsb_q;
  assign res_o   = res_q;
  assign b_o     = b_q;

endmodule
`default_nettype wire

// File: rtl/cla_sub_64_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cla_sub_64_pipe
// Description : Skewed, slice-per-stage pipelined subtractor a - b - bin.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_sub_64_pipe
  import cla_sub_64_pipe_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NS = WIDTH / SLICE_W;

  logic             w_valid [NS+1];
  logic             w_rdy   [NS+1];
  logic             w_carry [NS+1];
  logic             w_z     [NS+1];
  logic             w_amsb  [NS+1];
  logic [WIDTH-1:0] w_res   [NS+1];
  logic [WIDTH-1:0] w_b     [NS+1];

  // Subtract as a + ~b + ~bin: the incoming carry is the inverted borrow.
  assign w_valid[0] = in_valid;
  assign w_carry[0] = ~bin;
  assign w_z[0]     = 1'b1;
  assign w_amsb[0]  = a[WIDTH-1];
  assign w_res[0]   = a;
  assign w_b[0]     = b;
  assign w_rdy[NS]  = out_ready;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    cla_sub_16_stage #(
      .WIDTH  (WIDTH),
      .SLICE_W(SLICE_W),
      .IDX    (k)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid_i(w_valid[k]),
      .ready_o(w_rdy[k]),
      .ready_i(w_rdy[k+1]),
      .valid_o(w_valid[k+1]),
      .carry_i(w_carry[k]),
      .z_i    (w_z[k]),
      .amsb_i (w_amsb[k]),
      .res_i  (w_res[k]),
      .b_i    (w_b[k]),
      .carry_o(w_carry[k+1]),
      .z_o    (w_z[k+1]),
      .amsb_o (w_amsb[k+1]),
      .res_o  (w_res[k+1]),
      .b_o    (w_b[k+1])
    );
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = w_valid[NS];
  assign diff      = w_res[NS];
  assign bout      = ~w_carry[NS];
  assign zero      = w_z[NS];
  assign ovf       = (w_amsb[NS] ^ w_b[NS][WIDTH-1]) & (w_res[NS][WIDTH-1] ^ w_amsb[NS]);

endmodule
`default_nettype wire

// File: tb/tb_cla_sub_64_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_sub_64_pipe
// Description : Scoreboard bench for the pipelined 64-bit subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_sub_64_pipe;

  typedef struct packed {
    logic [63:0] d;
    logic        bo;
    logic        z;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        bin = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] diff;
  logic        bout;
  logic        zero;
  logic        ovf;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   stalls  = 0;
  int   cyc     = 0;
  logic held_v  = 1'b0;
  exp_t held;

  cla_sub_64_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .zero     (zero),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(logic [63:0] d, logic bo, logic z, logic ov);
    exp_t e;
    e.d = d; e.bo = bo; e.z = z; e.ov = ov;
    return e;
  endfunction

  // Reference: 65-bit subtraction; bit 64 is the borrow.
  function automatic exp_t model(logic [63:0] x, logic [63:0] y, logic bi);
    logic [64:0] t;
    t = {1'b0, x} - {1'b0, y} - {64'b0, bi};
    return mk(t[63:0], t[64], t[63:0] == 64'b0, (x[63] ^ y[63]) & (t[63] ^ x[63]));
  endfunction

  task automatic check(string nm, logic [66:0] act, logic [66:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic send(logic [63:0] x, logic [63:0] y, logic bi, exp_t e);
    logic ok;
    a = x; b = y; bin = bi; in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      if (!ok) stalls++;
      @(posedge clk);
    end while (!ok);
    q.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_empty", 67'(q.size()), 67'd0);
  endtask

  // Monitor: a transfer is pending whenever valid & ready are seen mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (held_v) begin
        check("stall_valid", {66'b0, out_valid}, 67'd1);
        check("stall_stable", {diff, bout, zero, ovf}, held);
      end
      held_v = out_valid & ~out_ready;
      held   = {diff, bout, zero, ovf};
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", {diff, bout, zero, ovf}, 67'd0 ^ {diff, bout, zero, ~ovf});
        end else begin
          check("result", {diff, bout, zero, ovf}, q.pop_front());
        end
      end
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    int cnt;
    int c0;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rbi;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {66'b0, out_valid}, 67'd0);
    check("rst_outputs", {diff, bout, zero, ovf}, 67'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {66'b0, in_ready}, 67'd1);
    out_ready = 1'b1;

    // Latency counted in rising edges, the transfer edge being the first.
    send(64'd5, 64'd3, 1'b0, mk(64'd2, 1'b0, 1'b0, 1'b0));
    cnt = 1;
    while (!out_valid && cnt < 12) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("latency", 67'(cnt), 67'd4);
    drain();

    send(64'd0, 64'd1, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0));
    send(64'd5, 64'd4, 1'b1, mk(64'd0, 1'b0, 1'b1, 1'b0));
    send(64'h0001_0000_0000_0000, 64'd1, 1'b0, mk(64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0));
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0, mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1));
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
         mk(64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1));
    send(64'd0, 64'd0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0));
    send(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, mk(64'd0, 1'b0, 1'b1, 1'b0));
    drain();

    stalls = 0;
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rbi = 1'($urandom_range(0, 1));
      send(ra, rb, rbi, model(ra, rb, rbi));
    end
    drain();
    check("stream_stalls", 67'(stalls), 67'd0);
    check("stream_cycles_ok", {66'b0, (cyc - c0) <= 108}, 67'd1);

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      send(ra, rb, 1'b0, model(ra, rb, 1'b0));
    end
    check("full_in_ready", {66'b0, in_ready}, 67'd0);
    check("full_out_valid", {66'b0, out_valid}, 67'd1);
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          ra = {$urandom, $urandom};
          rb = {$urandom, $urandom};
          rbi = 1'($urandom_range(0, 1));
          send(ra, rb, rbi, model(ra, rb, rbi));
        end
      end
      begin
        repeat (10) @(posedge clk);
        for (int i = 0; i < 80; i++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(64'd100 + 64'(i), 64'd1, 1'b0, mk(64'd99 + 64'(i), 1'b0, 1'b0, 1'b0));
    end
    rst_n = 1'b0;
    q.delete();
    #1;
    check("midrst_out_valid", {66'b0, out_valid}, 67'd0);
    check("midrst_outputs", {diff, bout, zero, ovf}, 67'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send(64'd10, 64'd7, 1'b0, mk(64'd3, 1'b0, 1'b0, 1'b0));
    drain();
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
